// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// f_mag serves operands up to MAX_W bits.
package div_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ABS,
        ITER,
        FIX
    } state_t;

    function automatic int f_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [MAX_W-1:0] f_mag(
        input logic [MAX_W-1:0] x,
        input logic             neg
    );
        return neg ? (~x + MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the quotient MSB into the remainder
// and subtract the divisor when the trial value allows it.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign w_trial = {i_rem, i_q[WIDTH-1]};
    assign w_ge    = w_trial >= {1'b0, i_div};
    // The remainder stays below the divisor, so the difference fits WIDTH bits
    assign w_diff  = w_trial[WIDTH-1:0] - i_div;
    assign o_rem   = w_ge ? w_diff : w_trial[WIDTH-1:0];
    assign o_q     = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/divisor_seq_param.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle.
// Define DIV_EARLY_TERM_EN to skip iteration when |Num| < |Den|. WIDTH <= 64.
module divisor_seq_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RSTa,
    input  logic             Start,
    input  logic             Sgn,
    input  logic [WIDTH-1:0] Num,
    input  logic [WIDTH-1:0] Den,
    output logic [WIDTH-1:0] Coc,
    output logic [WIDTH-1:0] Res,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic             Ovf
);

    localparam int               CNT_W = f_cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES  = '1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic             r_sgn;
    logic [WIDTH-1:0] r_dmag;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic             r_qneg;
    logic             r_rneg;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_nmag;
    logic [WIDTH-1:0] w_dmag;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_coc;
    logic [WIDTH-1:0] w_res;
    logic             w_dz;
    logic             w_ovf;
    logic             w_early;

    assign w_nmag = WIDTH'(f_mag(MAX_W'(r_num), r_sgn & r_num[WIDTH-1]));
    assign w_dmag = WIDTH'(f_mag(MAX_W'(r_den), r_sgn & r_den[WIDTH-1]));
    assign w_coc  = WIDTH'(f_mag(MAX_W'(r_q), r_qneg));
    assign w_res  = WIDTH'(f_mag(MAX_W'(r_rem), r_rneg));
    assign w_dz   = (r_den == '0);
    assign w_ovf  = r_sgn && (r_num == MIN) && (r_den == ONES);

`ifdef DIV_EARLY_TERM_EN
    assign w_early = (w_nmag < w_dmag);
`else
    assign w_early = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_q   (r_q),
        .i_div (r_dmag),
        .o_rem (w_rem_nx),
        .o_q   (w_q_nx)
    );

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            r_state <= IDLE;
            r_num   <= '0;
            r_den   <= '0;
            r_sgn   <= 1'b0;
            r_dmag  <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_cnt   <= '0;
            Coc     <= '0;
            Res     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        r_num   <= Num;
                        r_den   <= Den;
                        r_sgn   <= Sgn;
                        Busy    <= 1'b1;
                        r_state <= ABS;
                    end
                end
                ABS: begin
                    r_dmag <= w_dmag;
                    r_q    <= w_nmag;
                    r_rem  <= '0;
                    r_qneg <= r_sgn & (r_num[WIDTH-1] ^ r_den[WIDTH-1]);
                    r_rneg <= r_sgn & r_num[WIDTH-1];
                    r_cnt  <= LAST;
                    if (w_dz) begin
                        r_state <= FIX;
                    end else if (w_early) begin
                        // Quotient 0; re-signing |Num| in FIX restores Num
                        r_q     <= '0;
                        r_rem   <= w_nmag;
                        r_state <= FIX;
                    end else begin
                        r_state <= ITER;
                    end
                end
                ITER: begin
                    r_q   <= w_q_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    DivZero <= w_dz;
                    Ovf     <= w_ovf;
                    r_state <= IDLE;
                    if (w_dz) begin
                        Coc <= ONES;
                        Res <= r_num;
                    end else begin
                        Coc <= w_coc;
                        Res <= w_res;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_seq_param.sv
// Directed self-checking bench for divisor_seq_param at WIDTH=8.
// Early-termination latency follows DIV_EARLY_TERM_EN.
module tb_divisor_seq_param;

    localparam int W = 8;

`ifdef DIV_EARLY_TERM_EN
    localparam int LAT_ET = 2;
`else
    localparam int LAT_ET = 10;
`endif

    logic         CLK = 1'b0;
    logic         RSTa = 1'b0;
    logic         Start = 1'b0;
    logic         Sgn = 1'b0;
    logic [W-1:0] Num = '0;
    logic [W-1:0] Den = '0;
    logic [W-1:0] Coc;
    logic [W-1:0] Res;
    logic         Busy;
    logic         Done;
    logic         DivZero;
    logic         Ovf;

    int n_run  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    divisor_seq_param #(
        .WIDTH (W)
    ) dut (
        .CLK     (CLK),
        .RSTa    (RSTa),
        .Start   (Start),
        .Sgn     (Sgn),
        .Num     (Num),
        .Den     (Den),
        .Coc     (Coc),
        .Res     (Res),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .Ovf     (Ovf)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(
        input string        tag,
        input logic         s,
        input logic [W-1:0] n,
        input logic [W-1:0] d,
        input int           lat,
        input logic [W-1:0] ec,
        input logic [W-1:0] er,
        input logic         edz,
        input logic         eov
    );
        int   k;
        logic bz_ok;
        @(negedge CLK);
        Start = 1'b1;
        Sgn   = s;
        Num   = n;
        Den   = d;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        Sgn   = ~s;
        Num   = ~n;
        Den   = ~d;
        bz_ok = Busy;
        k     = 0;
        while (!Done && k < 40) begin
            @(posedge CLK);
            #1;
            k++;
            if (!Done && !Busy) bz_ok = 1'b0;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_busy"}, bz_ok, 1);
        chk({tag, "_busyoff"}, Busy, 0);
        chk({tag, "_coc"}, Coc, ec);
        chk({tag, "_res"}, Res, er);
        chk({tag, "_dz"}, DivZero, edz);
        chk({tag, "_ovf"}, Ovf, eov);
        @(posedge CLK);
        #1;
        chk({tag, "_pulse"}, Done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nd;
        int de [3];
        de = '{-1, -1, -1};

        #1;
        chk("rst_coc", Coc, 0);
        chk("rst_res", Res, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_dz", DivZero, 0);
        chk("rst_ovf", Ovf, 0);
        @(negedge CLK);
        RSTa = 1'b1;

        run_op("u100_7", 0, 8'd100, 8'd7, 10, 8'd14, 8'd2, 0, 0);
        run_op("s_m100_7", 1, 8'h9C, 8'd7, 10, 8'hF2, 8'hFE, 0, 0);
        run_op("s_100_m7", 1, 8'd100, 8'hF9, 10, 8'hF2, 8'h02, 0, 0);
        run_op("dz_u", 0, 8'h37, 8'h00, 2, 8'hFF, 8'h37, 1, 0);
        run_op("dz_s", 1, 8'h37, 8'h00, 2, 8'hFF, 8'h37, 1, 0);
        run_op("clr_dz", 0, 8'd100, 8'd7, 10, 8'd14, 8'd2, 0, 0);
        run_op("ovf", 1, 8'h80, 8'hFF, 10, 8'h80, 8'h00, 0, 1);
        run_op("u255", 0, 8'hFF, 8'hFF, 10, 8'h01, 8'h00, 0, 0);
        run_op("s_m128_2", 1, 8'h80, 8'h02, 10, 8'hC0, 8'h00, 0, 0);
        run_op("u200_3", 0, 8'd200, 8'd3, 10, 8'd66, 8'd2, 0, 0);
        run_op("early_u", 0, 8'd3, 8'd200, LAT_ET, 8'd0, 8'd3, 0, 0);
        run_op("early_s", 1, 8'hFD, 8'd7, LAT_ET, 8'd0, 8'hFD, 0, 0);

        // Start held high: a new operation launches from every Done cycle
        @(negedge CLK);
        Start = 1'b1;
        Sgn   = 1'b0;
        Num   = 8'd100;
        Den   = 8'd7;
        nd    = 0;
        for (int e = 0; e < 34; e++) begin
            @(posedge CLK);
            #1;
            if (Done) begin
                if (nd < 3) de[nd] = e;
                nd++;
            end
        end
        Start = 1'b0;
        chk("b2b_cnt", nd, 3);
        chk("b2b_d0", de[0], 10);
        chk("b2b_d1", de[1], 21);
        chk("b2b_d2", de[2], 32);
        chk("b2b_coc", Coc, 14);
        repeat (14) @(posedge CLK);
        #1;

        // Start pulsed while busy must be ignored
        @(negedge CLK);
        Start = 1'b1;
        Sgn   = 1'b0;
        Num   = 8'd200;
        Den   = 8'd3;
        nd    = 0;
        de[0] = -1;
        for (int e = 0; e < 25; e++) begin
            @(posedge CLK);
            #1;
            Start = (e == 3);
            Num   = 8'h37;
            Den   = 8'h00;
            if (Done) begin
                if (nd == 0) de[0] = e;
                nd++;
            end
        end
        chk("ign_cnt", nd, 1);
        chk("ign_lat", de[0], 10);
        chk("ign_coc", Coc, 66);
        chk("ign_res", Res, 2);
        chk("ign_dz", DivZero, 0);

        // Reset mid-operation
        @(negedge CLK);
        Start = 1'b1;
        Sgn   = 1'b0;
        Num   = 8'd100;
        Den   = 8'd7;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("pre_rst_busy", Busy, 1);
        chk("pre_rst_coc", Coc, 66);
        RSTa = 1'b0;
        #1;
        chk("mid_rst_coc", Coc, 0);
        chk("mid_rst_res", Res, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_done", Done, 0);
        @(negedge CLK);
        RSTa = 1'b1;
        nd   = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge CLK);
            #1;
            if (Done) nd++;
        end
        chk("post_rst_nodone", nd, 0);
        chk("post_rst_coc", Coc, 0);
        run_op("after_rst", 0, 8'd100, 8'd7, 10, 8'd14, 8'd2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
